rom_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the Hack instruction ROM. It accepts a byte stream (length header followed by big-endian 16-bit instruction words) over a valid/ready handshake and drives the ROM write port at consecutive addresses from 0. It holds the CPU in reset until the full image is written.

---
 rtl/rom_loader_pkg.sv | 24 ++
 rtl/rom_loader_byte_pair.sv | 63 ++++++
 rtl/rom_loader.sv | 143 ++++++++++++++
 tb/tb_rom_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared Hack definitions for the boot loader: default widths and loader state encoding.
package rom_loader_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_HI  = 3'd1,
    ST_HDR_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_FINISH  = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  // The loader takes bytes only while parsing the header or image words.
  function automatic logic state_accepts(input state_e s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

endpackage

// File: rtl/rom_loader_byte_pair.sv
// Latches the high byte of an image word and issues the registered ROM write.
module rom_loader_byte_pair
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hi_load,
  input  logic              lo_load,
  input  logic [7:0]        in_data,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  logic [7:0]        hi_q, hi_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // Next-state for the byte latch and write port; address/data hold between writes.
  always_comb begin
    hi_d      = hi_q;
    wr_en_d   = lo_load;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (hi_load) begin
      hi_d = in_data;
    end else begin
      hi_d = hi_q;
    end
    if (lo_load) begin
      wr_addr_d = addr_in;
      wr_data_d = {hi_q, in_data};
    end else begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  // Byte latch and write-port registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q      <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      hi_q      <= hi_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: rtl/rom_loader.sv
// Boot-time loader: parses a length-prefixed big-endian word stream into the
// instruction ROM and holds the CPU in reset until the image is complete.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int          CMP_W   = 17;
  localparam logic [16:0] DEPTH_C = 17'd1 << ADDR_W;

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              accept_s;
  logic [15:0]       hdr_n_s;
  logic              last_word_s;
  logic              hi_load_s;
  logic              lo_load_s;

  assign accept_s    = in_valid && in_ready;
  assign hdr_n_s     = {count_q[15:8], in_data};
  // The index has one spare bit so a full-depth image never wraps it.
  assign last_word_s = (CMP_W'(idx_q) + 17'd1) == CMP_W'(count_q);
  assign hi_load_s   = accept_s && (state_q == ST_DATA_HI);
  assign lo_load_s   = accept_s && (state_q == ST_DATA_LO);

  // Next-state, word count and address counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_HDR_HI;
        end else begin
          state_d = state_q;
        end
      end
      ST_HDR_HI: begin
        if (accept_s) begin
          count_d[15:8] = in_data;
          state_d       = ST_HDR_LO;
        end else begin
          state_d = ST_HDR_HI;
        end
      end
      ST_HDR_LO: begin
        if (accept_s) begin
          count_d = hdr_n_s;
          idx_d   = '0;
          if (hdr_n_s == 16'd0) begin
            state_d = ST_DONE;
          end else if (CMP_W'(hdr_n_s) > DEPTH_C) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA_HI;
          end
        end else begin
          state_d = ST_HDR_LO;
        end
      end
      ST_DATA_HI: begin
        if (accept_s) begin
          state_d = ST_DATA_LO;
        end else begin
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_LO: begin
        if (accept_s) begin
          idx_d = idx_q + {{ADDR_W{1'b0}}, 1'b1};
          if (last_word_s) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_DATA_HI;
          end
        end else begin
          state_d = ST_DATA_LO;
        end
      end
      ST_FINISH: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, count and address registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= 16'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = state_accepts(state_q);
  assign busy      = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                     (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                     (state_q == ST_FINISH);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERROR);
  assign cpu_reset = (state_q != ST_DONE);

  rom_loader_byte_pair #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_byte_pair (
    .clk     (clk),
    .rst_n   (rst_n),
    .hi_load (hi_load_s),
    .lo_load (lo_load_s),
    .in_data (in_data),
    .addr_in (idx_q[ADDR_W-1:0]),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_rom_loader.sv
// Randomised scoreboard bench for rom_loader: expected ROM writes are queued from
// the image model and a negedge monitor compares every write strobe against them.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] img[$];
  int          errors = 0;
  int          checks = 0;
  int          n_writes = 0;
  logic [14:0] last_addr = 15'd0;
  logic        prev_wr = 1'b0;

  always #5 clk = ~clk;

  rom_loader #(.ADDR_W(15), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Monitor: every write strobe must match the next expected write and last one cycle.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_t e;
      checks++;
      if (prev_wr) begin
        errors++;
        $display("FAIL wr_en_width: wr_en high two cycles in a row at addr %0h", wr_addr);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got (%0h,%0h), none expected", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          errors++;
          $display("FAIL write: got (%0h,%0h), expected (%0h,%0h)", wr_addr, wr_data, e.a, e.d);
        end
      end
      last_addr = wr_addr;
      n_writes++;
    end
    prev_wr = rst_n && wr_en;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one byte with random idle gaps; optionally wiggle start, which must be ignored.
  task automatic send_byte(input logic [7:0] b, input int stall_pct, input bit rnd_start);
    int n;
    while ($urandom_range(99) < stall_pct) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      start    = rnd_start ? 1'($urandom_range(1)) : 1'b0;
      @(posedge clk); #1;
      chk("gap_hold_ready", in_ready, 1);
    end
    in_data  = b;
    in_valid = 1'b1;
    start    = rnd_start ? 1'($urandom_range(1)) : 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: in_ready low for %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Load n words from img; the model decides the outcome from n alone.
  task automatic load(input logic [15:0] n, input int stall, input bit rnd_start);
    pulse_start();
    chk("start_busy", busy, 1);
    if (n != 16'd0 && n <= 16'h8000) begin
      for (int i = 0; i < int'(n); i++) exp_q.push_back('{a: 15'(i), d: img[i]});
    end
    send_byte(n[15:8], stall, rnd_start);
    send_byte(n[7:0], stall, rnd_start);
    if (n == 16'd0) begin
      chk("empty_done", done, 1);
      chk("empty_cpu_reset", cpu_reset, 0);
      chk("empty_busy", busy, 0);
    end else if (n > 16'h8000) begin
      chk("over_err", err, 1);
      chk("over_cpu_reset", cpu_reset, 1);
      chk("over_in_ready", in_ready, 0);
      chk("over_done", done, 0);
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        logic [15:0] w;
        w = img[i];
        send_byte(w[15:8], stall, rnd_start);
        send_byte(w[7:0], stall, rnd_start);
      end
      chk("last_wr_en", wr_en, 1);
      chk("finish_busy", busy, 1);
      chk("finish_done", done, 0);
      chk("finish_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("end_done", done, 1);
      chk("end_cpu_reset", cpu_reset, 0);
      chk("end_busy", busy, 0);
      chk("end_err", err, 0);
      chk("end_queue_empty", exp_q.size(), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values();
    rst_n = 1'b1;
    // Bytes offered in IDLE are ignored and the CPU stays held.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(posedge clk); #1;
      chk("idle_cpu_reset", cpu_reset, 1);
      chk("idle_busy", busy, 0);
    end
    in_valid = 1'b0;

    // Basic and stalled loads of the same image.
    img = '{16'h1234, 16'hABCD, 16'hFF00};
    n_writes = 0;
    load(16'd3, 0, 1'b0);
    chk("basic_writes", n_writes, 3);
    chk("basic_last_addr", last_addr, 2);
    n_writes = 0;
    load(16'd3, 40, 1'b0);
    chk("stall_writes", n_writes, 3);

    // Empty image.
    n_writes = 0;
    load(16'd0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("empty_writes", n_writes, 0);

    // Oversize header, then recovery.
    load(16'h8001, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(posedge clk); #1;
      chk("err_hold", err, 1);
    end
    in_valid = 1'b0;
    chk("over_writes", n_writes, 0);
    img = '{16'h1234};
    load(16'd1, 0, 1'b0);
    chk("recover_writes", n_writes, 1);

    // Random small images with stalls and ignored start pulses.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(6, 1);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
      load(16'(n), 30, 1'b1);
    end

    // Reset after the third data byte of a 4-word image.
    pulse_start();
    exp_q.push_back('{a: 15'd0, d: 16'h1111});
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_values();
    rst_n = 1'b1;
    chk("rst_queue_empty", exp_q.size(), 0);
    img = '{16'h5678, 16'h9ABC};
    load(16'd2, 0, 1'b0);

    // Full-depth image.
    img.delete();
    for (int i = 0; i < 32768; i++) img.push_back(16'(i));
    n_writes = 0;
    load(16'h8000, 0, 1'b0);
    chk("max_writes", n_writes, 32768);
    chk("max_last_addr", last_addr, 15'h7FFF);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
